linear_layer_srl_fifo_mc: RTL and testbench
===========================================

# linear_layer_srl_fifo_mc

Multi-channel, show-ahead, shift-register FIFO with per-channel write/read handshakes, occupancy counters and registered full/empty flags. It is a parametrised successor to the single-channel SRL storage used between dataflow processes of the linear-layer datapath (PE start tokens, packed i4 operand streams). It is generalised in data width, depth and channel count, and adds full/empty, occupancy and optional almost flags. It sits between producer and consumer PEs inside the Linear_Layer dataflow region.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per channel entry (>=1)
- DEPTH, 4, entries per channel (>=1)
- NUM_CH, 2, independent channels (>=1)
- AF_MARGIN, 1, almost-full margin (only with macro)
- AE_MARGIN, 1, almost-empty margin (only with macro)

Ports (CNT_W = $clog2(DEPTH+1)):
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- if_write  in  NUM_CH  per-channel write request
- if_din  in  NUM_CH*DATA_WIDTH  write data; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- if_full_n  out  NUM_CH  channel can accept a write
- if_read  in  NUM_CH  per-channel read request
- if_dout  out  NUM_CH*DATA_WIDTH  head entry of each channel (show-ahead)
- if_empty_n  out  NUM_CH  head entry valid
- if_count  out  NUM_CH*CNT_W  per-channel occupancy, 0..DEPTH
- if_almost_full  out  NUM_CH  only with macro
- if_almost_empty  out  NUM_CH  only with macro

## Operation
- Channels are fully independent. There is no shared state other than clock and reset.
- push[c] = if_write[c] & if_full_n[c]. pop[c] = if_read[c] & if_empty_n[c]. Requests against a deasserted flag are ignored with no state change.
- On push: the storage shifts by one (entry i -> i+1) and din goes to entry 0. Storage has no reset and is written only on push.
- Head address = count-1, width max(1,$clog2(DEPTH)).
- if_dout[c] = entry[count-1] when if_empty_n[c] = 1, otherwise 0. This output is combinational from registered state.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, and the shift still occurs; the head address is unchanged, so the next-oldest entry becomes head.
- Flags are registered from the next count:
  - if_full_n = (count_next < DEPTH)
  - if_empty_n = (count_next > 0)
- Full boundary: a write while full is rejected even if a read occurs in the same cycle. The read is accepted, and full_n rises next cycle.
- Empty boundary: a read while empty is rejected even if a write occurs in the same cycle. The write is accepted, and empty_n rises next cycle.
- No overflow or underflow is possible. Count never leaves 0..DEPTH.
- DEPTH = 1: acts as a single register slot; full_n and empty_n are complementary.

## Timing
- Reset values (async assert, synchronous release):
  - count = 0
  - if_empty_n = 0
  - if_full_n = 1
  - if_dout = 0
  - if_almost_empty = 1
  - if_almost_full = (DEPTH <= AF_MARGIN)
- Reset asserted mid-operation discards all contents immediately. Storage contents are don't-care afterwards.
- Write-to-read latency is 1 cycle. Data written at edge k is on if_dout with if_empty_n = 1 after edge k.
- Read-to-next-head is 1 cycle. Pop at edge k presents the next entry after edge k.
- Full throughput: one push and one pop per channel per cycle, sustained when 0 < count < DEPTH.
- Flags are never combinationally dependent on if_write or if_read.

## Configuration
- SRL_FIFO_ALMOST_FLAGS_EN defined:
  - if_almost_full = (count >= DEPTH-AF_MARGIN)
  - if_almost_empty = (count <= AE_MARGIN)
  - Both are registered from count_next, per channel.
- SRL_FIFO_ALMOST_FLAGS_EN undefined: both ports and their registers are absent. AF_MARGIN and AE_MARGIN are ignored.

## Structure
- Package linear_layer_fifo_pkg holds the CNT_W/ADDR_W clog2 helper function and the reset-value constants.
- Sub-module linear_layer_srl_store: one channel's shift storage (clk, we, addr, din, dout), with no reset. It is instantiated NUM_CH times in a generate loop.
- The top level holds per-channel count and flag registers and the output gating.

## Test plan
- Reset then idle, DEPTH=4, NUM_CH=2 -> count=0, empty_n=2'b00, full_n=2'b11, dout=0.
- Ch0: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, no reads -> full_n[0]=0 after 4th edge, count=4. A 5th write of 0x55 is ignored. Reads then return 0x11..0x44 in order, and empty_n[0]=0 after the last.
- Ch1: count=2, simultaneous write+read for 6 cycles -> count stays 2, dout follows FIFO order, no bubble. Ch0 is unaffected throughout.
- Full and simultaneous read+write on ch0 -> read accepted, write rejected, count=3, full_n=1 next cycle. Empty and simultaneous read+write -> write accepted, count=1.
- Assert ap_rst_n low asynchronously mid-burst at count=3 -> outputs take reset values without waiting for a clock edge. After release, the first write is read back correctly.
- With SRL_FIFO_ALMOST_FLAGS_EN, AF_MARGIN=1, AE_MARGIN=1 -> almost_full rises at count 3. almost_empty is 1 at counts 0..1 and 0 at count 2.

Source files
------------

// File: rtl/linear_layer_fifo_pkg.sv
// -----------------------------------------------------------------------------
// linear_layer_fifo_pkg
// Shared helpers and reset constants for the linear-layer SRL FIFO.
//   cnt_width(depth)  : bits needed to hold an occupancy of 0..depth
//   addr_width(depth) : bits needed to address depth entries (at least 1)
//   RST_*             : values the per-channel flag registers take in reset
// -----------------------------------------------------------------------------
package linear_layer_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam logic RST_EMPTY_N      = 1'b0;
  localparam logic RST_FULL_N       = 1'b1;
  localparam logic RST_ALMOST_EMPTY = 1'b1;

endpackage

// File: rtl/linear_layer_srl_store.sv
// -----------------------------------------------------------------------------
// linear_layer_srl_store
// One channel of shift-register storage. On we the contents shift up by one
// entry (i -> i+1) and din lands in entry 0. The read port is combinational.
// Ports:
//   clk  in   clock
//   we   in   shift enable (push)
//   addr in   read address (head = count-1)
//   din  in   entry written on push
//   dout out  entry at addr
// -----------------------------------------------------------------------------
module linear_layer_srl_store
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset on purpose; validity is tracked by
  // the occupancy counter, so resetting it would only cost flops and routing.
  // NOTE: non-blocking assignments make every entry read its neighbour's old
  // value, which is exactly the one-step shift we want.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_srl_fifo_mc.sv
// -----------------------------------------------------------------------------
// linear_layer_srl_fifo_mc
// Multi-channel show-ahead shift-register FIFO. Each channel is independent:
// it owns an SRL store, an occupancy counter and registered full/empty flags.
// Optional almost-full/almost-empty flags are built when the macro
// SRL_FIFO_ALMOST_FLAGS_EN is defined.
// Ports (per channel c, data at [c*DATA_WIDTH +: DATA_WIDTH]):
//   ap_clk          in   clock
//   ap_rst_n        in   asynchronous active-low reset
//   if_write        in   write request
//   if_din          in   write data
//   if_full_n       out  channel can accept a write
//   if_read         in   read request
//   if_dout         out  head entry, 0 while empty
//   if_empty_n      out  head entry valid
//   if_almost_full  out  count >= DEPTH-AF_MARGIN   (macro only)
//   if_almost_empty out  count <= AE_MARGIN         (macro only)
//   if_count        out  occupancy 0..DEPTH, CNT_W bits per channel
// -----------------------------------------------------------------------------
module linear_layer_srl_fifo_mc
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  localparam int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_CH-1:0]            if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] if_din,
  output logic [NUM_CH-1:0]            if_full_n,
  input  logic [NUM_CH-1:0]            if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0] if_dout,
  output logic [NUM_CH-1:0]            if_empty_n,
`ifdef SRL_FIFO_ALMOST_FLAGS_EN
  output logic [NUM_CH-1:0]            if_almost_full,
  output logic [NUM_CH-1:0]            if_almost_empty,
`endif
  output logic [NUM_CH*CNT_W-1:0]      if_count
);

  localparam int ADDR_W = addr_width(DEPTH);

  // Elaboration-time sanity check on the configuration.
  if (DATA_WIDTH < 1 || DEPTH < 1 || NUM_CH < 1 || AF_MARGIN < 0 || AE_MARGIN < 0)
  begin : g_param_check
    $error("linear_layer_srl_fifo_mc: illegal parameter combination");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_next;
    logic [CNT_W-1:0]      head;
    logic [ADDR_W-1:0]     addr;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] store_dout;

    // Accept only against the registered flags, so a write while full or a
    // read while empty is dropped even if the other side moves this cycle.
    assign push = if_write[c] & full_n_q;
    assign pop  = if_read[c]  & empty_n_q;

    // NOTE: count_next is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
      count_next = count_q;
      if (push && !pop) begin
        count_next = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count_q - CNT_W'(1);
      end
    end

    // While empty the head would wrap; pin it to 0 so it stays in range
    // (the output is gated to 0 then anyway).
    assign head = count_q - CNT_W'(1);
    assign addr = empty_n_q ? head[ADDR_W-1:0] : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        count_q   <= '0;
        full_n_q  <= RST_FULL_N;
        empty_n_q <= RST_EMPTY_N;
      end else begin
        count_q   <= count_next;
        full_n_q  <= (count_next < CNT_W'(DEPTH));
        empty_n_q <= (count_next != '0);
      end
    end

    linear_layer_srl_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
    ) u_store (
      .clk  (ap_clk),
      .we   (push),
      .addr (addr),
      .din  (if_din[c*DATA_WIDTH +: DATA_WIDTH]),
      .dout (store_dout)
    );

    assign if_full_n[c]                          = full_n_q;
    assign if_empty_n[c]                         = empty_n_q;
    assign if_count[c*CNT_W +: CNT_W]            = count_q;
    assign if_dout[c*DATA_WIDTH +: DATA_WIDTH]   = empty_n_q ? store_dout : '0;

`ifdef SRL_FIFO_ALMOST_FLAGS_EN
    logic almost_full_q;
    logic almost_empty_q;

    // Margins are compared in int so a margin >= DEPTH saturates cleanly.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        almost_full_q  <= (DEPTH <= AF_MARGIN);
        almost_empty_q <= RST_ALMOST_EMPTY;
      end else begin
        almost_full_q  <= (int'(count_next) + AF_MARGIN >= DEPTH);
        almost_empty_q <= (int'(count_next) <= AE_MARGIN);
      end
    end

    assign if_almost_full[c]  = almost_full_q;
    assign if_almost_empty[c] = almost_empty_q;
`endif
  end

endmodule

// File: tb/tb_linear_layer_srl_fifo_mc.sv
// -----------------------------------------------------------------------------
// tb_linear_layer_srl_fifo_mc
// Self-checking bench for linear_layer_srl_fifo_mc (DEPTH=4, NUM_CH=2).
// A per-channel queue holds the expected contents: accepted writes are pushed,
// accepted reads pop and compare against the DUT head. Inputs change on the
// falling edge; outputs are sampled there too, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_linear_layer_srl_fifo_mc;

  localparam int DW        = 8;
  localparam int DEPTH     = 4;
  localparam int NUM_CH    = 2;
  localparam int AF_MARGIN = 1;
  localparam int AE_MARGIN = 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                    ap_clk = 1'b0;
  logic                    ap_rst_n;
  logic [NUM_CH-1:0]       if_write;
  logic [NUM_CH*DW-1:0]    if_din;
  logic [NUM_CH-1:0]       if_full_n;
  logic [NUM_CH-1:0]       if_read;
  logic [NUM_CH*DW-1:0]    if_dout;
  logic [NUM_CH-1:0]       if_empty_n;
  logic [NUM_CH*CNT_W-1:0] if_count;
`ifdef SRL_FIFO_ALMOST_FLAGS_EN
  logic [NUM_CH-1:0]       if_almost_full;
  logic [NUM_CH-1:0]       if_almost_empty;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [NUM_CH][$];

  always #5 ap_clk = ~ap_clk;

  linear_layer_srl_fifo_mc #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_CH     (NUM_CH),
    .AF_MARGIN  (AF_MARGIN),
    .AE_MARGIN  (AE_MARGIN)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .if_write        (if_write),
    .if_din          (if_din),
    .if_full_n       (if_full_n),
    .if_read         (if_read),
    .if_dout         (if_dout),
    .if_empty_n      (if_empty_n),
`ifdef SRL_FIFO_ALMOST_FLAGS_EN
    .if_almost_full  (if_almost_full),
    .if_almost_empty (if_almost_empty),
`endif
    .if_count        (if_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every per-channel output against the scoreboard occupancy/head.
  task automatic check_state();
    for (int c = 0; c < NUM_CH; c++) begin
      int sz;
      logic [DW-1:0] head;
      sz   = sb[c].size();
      head = (sz > 0) ? sb[c][0] : '0;
      check($sformatf("count%0d", c),   32'(if_count[c*CNT_W +: CNT_W]), 32'(sz));
      check($sformatf("full_n%0d", c),  32'(if_full_n[c]),  32'(sz < DEPTH));
      check($sformatf("empty_n%0d", c), 32'(if_empty_n[c]), 32'(sz > 0));
      check($sformatf("dout%0d", c),    32'(if_dout[c*DW +: DW]), 32'(head));
`ifdef SRL_FIFO_ALMOST_FLAGS_EN
      check($sformatf("almost_full%0d", c),  32'(if_almost_full[c]),  32'(sz >= DEPTH - AF_MARGIN));
      check($sformatf("almost_empty%0d", c), 32'(if_almost_empty[c]), 32'(sz <= AE_MARGIN));
`endif
    end
  endtask

  // One clock: drive requests (called on the falling edge), update the
  // scoreboard from the flags as the model sees them, clock, then check.
  task automatic cycle(input logic [NUM_CH-1:0] wr, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic [NUM_CH-1:0] rd);
    logic [DW-1:0] din [NUM_CH];
    din[0] = d0;
    din[1] = d1;
    if_write = wr;
    if_din   = {d1, d0};
    if_read  = rd;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      int sz;
      sz = sb[c].size();
      if (rd[c] && sz > 0) begin
        logic [DW-1:0] exp;
        exp = sb[c].pop_front();
        check($sformatf("pop%0d", c), 32'(if_dout[c*DW +: DW]), 32'(exp));
      end
      if (wr[c] && sz < DEPTH) sb[c].push_back(din[c]);
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    if_write = '0;
    if_read  = '0;
    check_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0;
    if_write = '0;
    if_read  = '0;
    if_din   = '0;
    repeat (2) @(negedge ap_clk);
    check_state();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_state();

    // Fill ch0; the 5th write hits full and must be dropped.
    cycle(2'b01, 8'h11, 8'h00, 2'b00);
    cycle(2'b01, 8'h22, 8'h00, 2'b00);
    cycle(2'b01, 8'h33, 8'h00, 2'b00);
    cycle(2'b01, 8'h44, 8'h00, 2'b00);
    check("full_n0_after_fill", 32'(if_full_n[0]), 32'd0);
    cycle(2'b01, 8'h55, 8'h00, 2'b00);

    // Full + read + write on ch0: read wins, write rejected, count 3.
    cycle(2'b01, 8'h66, 8'h00, 2'b01);
    check("count0_full_rw", 32'(if_count[0 +: CNT_W]), 32'd3);

    // Drain ch0 in order.
    repeat (3) cycle(2'b00, 8'h00, 8'h00, 2'b01);
    check("empty_n0_drained", 32'(if_empty_n[0]), 32'd0);

    // Empty + read + write on ch0: write accepted, count 1.
    cycle(2'b01, 8'h77, 8'h00, 2'b01);
    check("count0_empty_rw", 32'(if_count[0 +: CNT_W]), 32'd1);
    cycle(2'b00, 8'h00, 8'h00, 2'b01);

    // Ch1 streaming at count 2 with simultaneous read+write, no bubble.
    cycle(2'b10, 8'h00, 8'hA0, 2'b00);
    cycle(2'b10, 8'h00, 8'hA1, 2'b00);
    for (int i = 0; i < 6; i++) begin
      cycle(2'b10, 8'h00, 8'(8'hB0 + i), 2'b10);
      check("count1_stream", 32'(if_count[CNT_W +: CNT_W]), 32'd2);
    end
    repeat (2) cycle(2'b00, 8'h00, 8'h00, 2'b10);

    // Random traffic on both channels.
    for (int i = 0; i < 300; i++) begin
      cycle(2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    end
    repeat (DEPTH) cycle(2'b00, 8'h00, 8'h00, 2'b11);

    // Async reset mid-burst at ch0 count 3.
    cycle(2'b11, 8'hC1, 8'hD1, 2'b00);
    cycle(2'b11, 8'hC2, 8'hD2, 2'b00);
    cycle(2'b01, 8'hC3, 8'h00, 2'b00);
    if_write = 2'b11;
    if_din   = {8'hD9, 8'hC9};
    #2;
    ap_rst_n = 1'b0;
    #1;
    for (int c = 0; c < NUM_CH; c++) sb[c].delete();
    check_state();
    if_write = '0;
    @(negedge ap_clk);
    check_state();
    ap_rst_n = 1'b1;
    cycle(2'b01, 8'h5A, 8'h00, 2'b00);
    cycle(2'b00, 8'h00, 8'h00, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
